sd_spi_cmd: RTL and testbench
=============================

# sd_spi_cmd

SPI-mode SD card command initiator. It serialises one 48-bit SD command frame (start bits, index, argument, CRC7, end bit) onto the card's SPI pins, then polls the card with 0xFF bytes until an R1 response arrives or a poll limit expires. It sits between the game's storage/asset loader FSM and the SD card pins, on the host (master) side of the card's SPI link. Sector-data reads are layered on top by the loader.

## Interface
Parameters:
- `CLK_DIV`, 4: `clk` cycles per `sd_sclk` half-period. Must be ≥1.
- `RESP_TIMEOUT`, 8: maximum number of poll bytes before the command is abandoned. Must be ≥1.

Ports:
- `clk`, in, 1: system clock. One clock domain.
- `rst`, in, 1: **reset is synchronous and active-high**.
- `start`, in, 1: request a command. Accepted only while `busy`=0.
- `cmd_idx`, in, 6: command index. Latched on accept.
- `cmd_arg`, in, 32: command argument. Latched on accept.
- `cmd_crc`, in, 7: CRC7 field. Latched on accept; not computed here.
- `busy`, out, 1: a command is in progress.
- `done`, out, 1: one-cycle pulse when the command completes.
- `r1`, out, 8: last R1 response. Reads 0xFF on timeout.
- `timeout`, out, 1: the last command got no response.
- `sd_cs_n`, out, 1: card chip select, active low.
- `sd_sclk`, out, 1: SPI clock, mode 0 (idles low).
- `sd_mosi`, out, 1: data to the card. Idles high.
- `sd_miso`, in, 1: data from the card.

## Operation
- States: IDLE, CMD (6 frame bytes), POLL, FINISH.
- IDLE:
  - `start`=1 latches the inputs; next state is CMD.
  - Also clears `timeout` and the poll counter.
- CMD: transmits these bytes, MSB first:
  - {2'b01, idx}
  - arg[31:24], arg[23:16], arg[15:8], arg[7:0]
  - {crc, 1'b1}
  - Received bytes are discarded.
- POLL: transmits 0xFF and increments the poll counter on each received byte.
  - If the received bit7 is 0: latch `r1` = byte, go to FINISH.
  - Else, if the counter equals `RESP_TIMEOUT`: set `r1`=0xFF and `timeout`=1, go to FINISH.
  - Else: send another 0xFF.
- FINISH (single cycle): `sd_cs_n`←1, `done`←1, `busy`←0, return to IDLE.
- Chip select: `sd_cs_n` is low from the cycle after accept through the end of the last poll byte.
- Mode 0 bit rules:
  - `sd_mosi` is set while `sd_sclk` is low.
  - `sd_miso` is sampled on the `clk` edge that drives `sd_sclk` high. No synchroniser is used: MISO is launched by the card off our own `sd_sclk`.
- `start` while `busy`=1 is ignored. Input changes while busy have no effect.
- `r1` and `timeout` hold their values until the next accepted `start`.
- Reset mid-operation: on the next edge the block returns to IDLE. The byte in flight is abandoned and no `done` is produced.

## Timing
- Reset values: `busy`=0, `done`=0, `r1`=0xFF, `timeout`=0, `sd_cs_n`=1, `sd_sclk`=0, `sd_mosi`=1.
- Accept edge T: `busy`=1 and `sd_cs_n`=0 from T+1.
- First `sd_sclk` rise at T+1+`CLK_DIV`.
- One byte takes 16·`CLK_DIV` cycles: 8 low halves and 8 high halves. Bytes are back-to-back with no gap.
- The MSB is on `sd_mosi` from the first cycle of each byte's first low half.
- FINISH is entered on the edge that ends the 8th high half of the final poll byte. `done` is high the cycle after, for exactly one cycle. `busy`=0 and `sd_cs_n`=1 in that same cycle.
- Latency from accept to the `done` cycle is 2 + (6+k)·16·`CLK_DIV` cycles, where k is the number of poll bytes (1..`RESP_TIMEOUT`).
- A new `start` is accepted in the cycle `done` is high.

## Structure
- `sd_defs.vh` (shared include) holds:
  - frame start/end bit constants
  - the 0xFF fill byte
  - the state encodings
  - command index constants: CMD0=0, CMD8=8, CMD17=17, CMD55=55, ACMD41=41
- One natural sub-module: `sd_spi_byte`, an 8-bit mode-0 transceiver.
  - Ports: `clk`, `rst`, `go`, `tx`[8], `rx`[8], `rdy`, plus the `sclk`/`mosi`/`miso` pins.
  - Owns the divider and the bit counter.
  - `go` is accepted when `rdy`=1. `rdy` is a one-cycle pulse at byte end, with `rx` valid in that cycle.
- The top level owns the FSM, byte index, poll counter and `sd_cs_n`.

## Test plan
- **CMD0:** idx=0, arg=0, crc=0x4A, `CLK_DIV`=4. The card model answers 0x01 on the 2nd poll byte.
  - `sd_mosi` carries 40 00 00 00 00 95 FF FF.
  - `r1`=0x01, `timeout`=0.
  - `done` falls exactly at accept+2+8·64 cycles.
- **CMD8:** arg=0x1AA, crc=0x43, `CLK_DIV`=1.
  - Frame is 48 00 00 01 AA 87.
  - `sd_sclk` period is 2 cycles.
  - A response of 0x05 on the 1st poll gives `r1`=0x05.
- **Timeout:** `sd_miso` tied high, `RESP_TIMEOUT`=8.
  - Exactly 14 bytes are clocked.
  - `r1`=0xFF, `timeout`=1.
  - `sd_cs_n` rises with `done`.
- **Start while busy:** pulse `start` with idx=17 mid-frame.
  - It is ignored and the frame is unchanged.
  - A second `start` in the `done` cycle is accepted.
- **Reset mid-frame:** assert `rst` during byte 3.
  - Next cycle: `sd_cs_n`=1, `sd_sclk`=0, `sd_mosi`=1, `busy`=0, `r1`=0xFF.
  - No `done` pulse.
- **Bit ordering:** idx=0x3F, arg=0xA5C3_0F81, crc=0x7F.
  - The card model checks each bit is sampled on the rising edge.
  - It receives 7F A5 C3 0F 81 FF.

Source files
------------

// File: rtl/sd_spi_cmd_pkg.sv
// Shared definitions for the SPI-mode SD command initiator: frame constants,
// command indices, FSM encoding and the helper that builds frame bytes.
package sd_spi_cmd_pkg;

    localparam logic [1:0] FRAME_START  = 2'b01;
    localparam logic       FRAME_END    = 1'b1;
    localparam logic [7:0] FILL_BYTE    = 8'hFF;
    localparam int         FRAME_BYTES  = 6;

    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD8   = 6'd8;
    localparam logic [5:0] CMD17  = 6'd17;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] ACMD41 = 6'd41;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_POLL,
        ST_FINISH
    } state_e;

    typedef struct packed {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [6:0]  crc;
    } cmd_t;

    function automatic logic [7:0] frame_byte(input cmd_t c, input logic [2:0] n);
        logic [7:0] b;
        case (n)
            3'd0:    b = {FRAME_START, c.idx};
            3'd1:    b = c.arg[31:24];
            3'd2:    b = c.arg[23:16];
            3'd3:    b = c.arg[15:8];
            3'd4:    b = c.arg[7:0];
            3'd5:    b = {c.crc, FRAME_END};
            default: b = FILL_BYTE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sd_spi_byte.sv
// Mode-0 SPI byte transceiver: 16*CLK_DIV cycles per byte, MSB first.
// rdy pulses in the last cycle of a byte; a go in that cycle chains the next byte with no gap.
module sd_spi_byte #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [7:0] tx,
    output logic [7:0] rx,
    output logic       rdy,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);

    localparam int             DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

    logic          active_q, active_d;
    logic          sclk_q,   sclk_d;
    logic          mosi_q,   mosi_d;
    logic [DW-1:0] div_q,    div_d;
    logic [2:0]    bit_q,    bit_d;
    logic [6:0]    sh_q,     sh_d;
    logic [7:0]    rx_q,     rx_d;
    logic          half_end;
    logic          accept;

    always_comb begin
        half_end = (div_q == DIV_LAST);
        rdy      = active_q && sclk_q && half_end && (bit_q == 3'd7);
        accept   = go && (!active_q || rdy);

        active_d = active_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        div_d    = div_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        rx_d     = rx_q;

        if (accept) begin
            active_d = 1'b1;
            sclk_d   = 1'b0;
            div_d    = '0;
            bit_d    = 3'd0;
            sh_d     = tx[6:0];
            mosi_d   = tx[7];
        end else if (active_q) begin
            if (!half_end) begin
                div_d = div_q + 1'b1;
            end else begin
                div_d = '0;
                if (!sclk_q) begin
                    // MISO is launched by the card off our falling edge, so it is stable here.
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[6:0], miso};
                end else begin
                    sclk_d = 1'b0;
                    if (bit_q == 3'd7) begin
                        active_d = 1'b0;
                        mosi_d   = 1'b1;
                    end else begin
                        bit_d  = bit_q + 3'd1;
                        mosi_d = sh_q[6];
                        sh_d   = {sh_q[5:0], 1'b0};
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b1;
            div_q    <= '0;
            bit_q    <= 3'd0;
            sh_q     <= '0;
            rx_q     <= 8'hFF;
        end else begin
            active_q <= active_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            rx_q     <= rx_d;
        end
    end

    assign rx   = rx_q;
    assign sclk = sclk_q;
    assign mosi = mosi_q;

endmodule

// File: rtl/sd_spi_cmd.sv
// SD SPI command initiator: sends a 6-byte frame then polls with 0xFF for an R1 byte.
// done arrives 2 + (6+k)*16*CLK_DIV cycles after accept; start is ignored while busy.
module sd_spi_cmd
    import sd_spi_cmd_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int RESP_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  cmd_idx,
    input  logic [31:0] cmd_arg,
    input  logic [6:0]  cmd_crc,
    output logic        busy,
    output logic        done,
    output logic [7:0]  r1,
    output logic        timeout,
    output logic        sd_cs_n,
    output logic        sd_sclk,
    output logic        sd_mosi,
    input  logic        sd_miso
);

    localparam int PW = $clog2(RESP_TIMEOUT + 1);

    state_e        state_q,    state_d;
    cmd_t          cmd_q,      cmd_d;
    logic [2:0]    byte_idx_q, byte_idx_d;
    logic [PW-1:0] poll_q,     poll_d;
    logic          busy_q,     busy_d;
    logic          done_q,     done_d;
    logic [7:0]    r1_q,       r1_d;
    logic          timeout_q,  timeout_d;
    logic          cs_n_q,     cs_n_d;

    cmd_t       cmd_in;
    logic       go;
    logic [7:0] tx;
    logic [7:0] rx;
    logic       rdy;

    assign cmd_in = {cmd_idx, cmd_arg, cmd_crc};

    sd_spi_byte #(
        .CLK_DIV (CLK_DIV)
    ) u_byte (
        .clk  (clk),
        .rst  (rst),
        .go   (go),
        .tx   (tx),
        .rx   (rx),
        .rdy  (rdy),
        .sclk (sd_sclk),
        .mosi (sd_mosi),
        .miso (sd_miso)
    );

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        byte_idx_d = byte_idx_q;
        poll_d     = poll_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        r1_d       = r1_q;
        timeout_d  = timeout_q;
        cs_n_d     = cs_n_q;
        go         = 1'b0;
        tx         = FILL_BYTE;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // First byte goes straight from the inputs so SCLK can rise at T+1+CLK_DIV.
                    cmd_d      = cmd_in;
                    byte_idx_d = 3'd0;
                    poll_d     = '0;
                    timeout_d  = 1'b0;
                    busy_d     = 1'b1;
                    cs_n_d     = 1'b0;
                    go         = 1'b1;
                    tx         = frame_byte(cmd_in, 3'd0);
                    state_d    = ST_CMD;
                end
            end
            ST_CMD: begin
                if (rdy) begin
                    go = 1'b1;
                    if (byte_idx_q == 3'(FRAME_BYTES - 1)) begin
                        tx      = FILL_BYTE;
                        state_d = ST_POLL;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        tx         = frame_byte(cmd_q, byte_idx_q + 3'd1);
                    end
                end
            end
            ST_POLL: begin
                if (rdy) begin
                    poll_d = poll_q + 1'b1;
                    if (!rx[7]) begin
                        r1_d    = rx;
                        state_d = ST_FINISH;
                    end else if (poll_d == PW'(RESP_TIMEOUT)) begin
                        r1_d      = FILL_BYTE;
                        timeout_d = 1'b1;
                        state_d   = ST_FINISH;
                    end else begin
                        go = 1'b1;
                        tx = FILL_BYTE;
                    end
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                cs_n_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            byte_idx_q <= 3'd0;
            poll_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            r1_q       <= FILL_BYTE;
            timeout_q  <= 1'b0;
            cs_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            byte_idx_q <= byte_idx_d;
            poll_q     <= poll_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            r1_q       <= r1_d;
            timeout_q  <= timeout_d;
            cs_n_q     <= cs_n_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign r1      = r1_q;
    assign timeout = timeout_q;
    assign sd_cs_n = cs_n_q;

endmodule

// File: tb/tb_sd_spi_cmd.sv
// Bench for sd_spi_cmd: two instances (CLK_DIV 4 and 1) driven by a pin-level SD card model.
module tb_sd_spi_cmd;
    import sd_spi_cmd_pkg::*;

    localparam int RT = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  start;
    logic [5:0]  cmd_idx;
    logic [31:0] cmd_arg;
    logic [6:0]  cmd_crc;
    logic [1:0]  miso = 2'b11;
    wire  [1:0]  busy, done, timeout, cs_n, sclk, mosi;
    wire  [7:0]  r1 [2];

    sd_spi_cmd #(.CLK_DIV(4), .RESP_TIMEOUT(RT)) u_dut_div4 (
        .clk(clk), .rst(rst), .start(start[0]), .cmd_idx(cmd_idx), .cmd_arg(cmd_arg),
        .cmd_crc(cmd_crc), .busy(busy[0]), .done(done[0]), .r1(r1[0]), .timeout(timeout[0]),
        .sd_cs_n(cs_n[0]), .sd_sclk(sclk[0]), .sd_mosi(mosi[0]), .sd_miso(miso[0])
    );

    sd_spi_cmd #(.CLK_DIV(1), .RESP_TIMEOUT(RT)) u_dut_div1 (
        .clk(clk), .rst(rst), .start(start[1]), .cmd_idx(cmd_idx), .cmd_arg(cmd_arg),
        .cmd_crc(cmd_crc), .busy(busy[1]), .done(done[1]), .r1(r1[1]), .timeout(timeout[1]),
        .sd_cs_n(cs_n[1]), .sd_sclk(sclk[1]), .sd_mosi(mosi[1]), .sd_miso(miso[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Card model state, owned by the card process except for the response plan.
    int         resp_at  [2] = '{0, 0};
    logic [7:0] resp_val [2] = '{8'hFF, 8'hFF};
    logic [7:0] cap [2][32];
    int         cap_n    [2] = '{0, 0};
    int         bitn     [2] = '{0, 0};
    logic [7:0] shreg    [2] = '{8'h00, 8'h00};
    logic       held     [2] = '{1'b1, 1'b1};
    logic       sclk_prev[2] = '{1'b0, 1'b0};
    int         viol     [2] = '{0, 0};
    int         done_cnt [2] = '{0, 0};
    int         last_rise[2] = '{0, 0};
    int         rise_gap [2] = '{0, 0};
    int         cyc = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Card: latches MOSI on SCLK rise, launches MISO after SCLK fall, answers on a chosen poll byte.
    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (done[i] === 1'b1) done_cnt[i]++;
            if (cs_n[i] !== 1'b0) begin
                bitn[i] = 0;
                miso[i] = 1'b1;
            end else begin
                if (sclk[i] && !sclk_prev[i]) begin
                    if (bitn[i] == 0) cap_n[i] = 0;
                    shreg[i] = {shreg[i][6:0], mosi[i]};
                    held[i]  = mosi[i];
                    bitn[i]++;
                    rise_gap[i]  = cyc - last_rise[i];
                    last_rise[i] = cyc;
                    if (bitn[i] % 8 == 0 && cap_n[i] < 32) begin
                        cap[i][cap_n[i]] = shreg[i];
                        cap_n[i]++;
                    end
                end else if (sclk[i] && mosi[i] !== held[i]) begin
                    viol[i]++;
                end
                if (!sclk[i] && sclk_prev[i]) begin
                    if (resp_at[i] >= 1 && bitn[i] / 8 == 5 + resp_at[i])
                        miso[i] = resp_val[i][7 - bitn[i] % 8];
                    else
                        miso[i] = 1'b1;
                end
            end
            sclk_prev[i] = sclk[i];
        end
    end

    task automatic launch(input int w, input logic [5:0] idx, input logic [31:0] arg,
                          input logic [6:0] crc, input int rat, input logic [7:0] rval);
        resp_at[w]  = rat;
        resp_val[w] = rval;
        cmd_idx     = idx;
        cmd_arg     = arg;
        cmd_crc     = crc;
        start[w]    = 1'b1;
    endtask

    // Follows one accepted command to its done cycle and checks it against the frame rules.
    task automatic finish_cmd(input int w, input logic [5:0] idx, input logic [31:0] arg,
                              input logic [6:0] crc, input int poke_at);
        int d, k, c, lim, bad;
        logic [7:0] exp_frame [6];
        logic [7:0] exp_r1;
        logic       exp_to;
        logic       prev_cs;
        d = (w == 0) ? 4 : 1;
        if (resp_at[w] >= 1 && resp_at[w] <= RT && resp_val[w][7] == 1'b0) begin
            k = resp_at[w]; exp_r1 = resp_val[w]; exp_to = 1'b0;
        end else begin
            k = RT; exp_r1 = 8'hFF; exp_to = 1'b1;
        end
        exp_frame[0] = {2'b01, idx};
        for (int i = 0; i < 4; i++) exp_frame[1 + i] = 8'(arg >> (24 - 8 * i));
        exp_frame[5] = {crc, 1'b1};
        lim = 2 + (6 + RT) * 16 * d + 20;

        @(negedge clk);
        c = 1;
        start[w] = 1'b0;
        chk_eq("acc_busy", busy[w], 1);
        chk_eq("acc_cs_n", cs_n[w], 0);
        chk_eq("acc_done", done[w], 0);
        prev_cs = cs_n[w];
        while (done[w] !== 1'b1 && c < lim) begin
            prev_cs = cs_n[w];
            @(negedge clk);
            c++;
            if (c == poke_at) begin
                start[w] = 1'b1;
                cmd_idx  = 6'd17;
                cmd_arg  = $urandom;
                cmd_crc  = 7'($urandom);
            end else if (c == poke_at + 1) begin
                start[w] = 1'b0;
            end
        end
        chk_eq($sformatf("latency_w%0d", w), c, 2 + (6 + k) * 16 * d);
        chk_eq("r1", r1[w], exp_r1);
        chk_eq("timeout", timeout[w], exp_to);
        chk_eq("done_busy", busy[w], 0);
        chk_eq("done_cs_n", cs_n[w], 1);
        chk_eq("cs_n_before_done", prev_cs, 0);
        for (int i = 0; i < 6; i++)
            chk_eq($sformatf("frame_byte%0d", i), cap[w][i], exp_frame[i]);
        chk_eq("bytes_clocked", cap_n[w], 6 + k);
        bad = 0;
        for (int i = 6; i < 6 + k && i < 32; i++) if (cap[w][i] !== 8'hFF) bad++;
        chk_eq("poll_fill", bad, 0);
        chk_eq("mosi_stable_high", viol[w], 0);
    endtask

    task automatic run_cmd(input int w, input logic [5:0] idx, input logic [31:0] arg,
                           input logic [6:0] crc, input int rat, input logic [7:0] rval,
                           input int poke_at);
        @(negedge clk);
        launch(w, idx, arg, crc, rat, rval);
        finish_cmd(w, idx, arg, crc, poke_at);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dc;
        logic [5:0]  ridx;
        logic [31:0] rarg;
        logic [6:0]  rcrc;
        logic [7:0]  rval;
        rst = 1'b1;
        start = 2'b00;
        cmd_idx = '0;
        cmd_arg = '0;
        cmd_crc = '0;
        repeat (3) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            chk_eq("rst_busy", busy[w], 0);
            chk_eq("rst_done", done[w], 0);
            chk_eq("rst_r1", r1[w], 8'hFF);
            chk_eq("rst_timeout", timeout[w], 0);
            chk_eq("rst_cs_n", cs_n[w], 1);
            chk_eq("rst_sclk", sclk[w], 0);
            chk_eq("rst_mosi", mosi[w], 1);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // CMD0, answered 0x01 on the 2nd poll byte.
        run_cmd(0, CMD0, 32'h0, 7'h4A, 2, 8'h01, 0);
        chk_eq("cmd0_sclk_period", rise_gap[0], 8);

        // CMD8 at CLK_DIV=1, answered 0x05 on the 1st poll byte.
        run_cmd(1, CMD8, 32'h0000_01AA, 7'h43, 1, 8'h05, 0);
        chk_eq("cmd8_sclk_period", rise_gap[1], 2);

        // No response at all.
        run_cmd(0, CMD17, 32'h0000_0200, 7'h2B, 0, 8'hFF, 0);

        // Start pulsed mid-frame is ignored; a start in the done cycle is taken.
        run_cmd(0, CMD55, 32'h0, 7'h32, 3, 8'h00, 100);
        launch(0, ACMD41, 32'h4000_0000, 7'h3B, 1, 8'h01);
        finish_cmd(0, ACMD41, 32'h4000_0000, 7'h3B, 0);

        // Bit ordering.
        run_cmd(1, 6'h3F, 32'hA5C3_0F81, 7'h7F, 1, 8'h00, 0);

        // Reset during byte 3 of a frame.
        @(negedge clk);
        launch(0, CMD17, 32'h1234_5678, 7'h11, 1, 8'h00);
        @(negedge clk);
        start[0] = 1'b0;
        repeat (3 * 64 + 19) @(negedge clk);
        dc = done_cnt[0];
        rst = 1'b1;
        @(negedge clk);
        chk_eq("mid_rst_cs_n", cs_n[0], 1);
        chk_eq("mid_rst_sclk", sclk[0], 0);
        chk_eq("mid_rst_mosi", mosi[0], 1);
        chk_eq("mid_rst_busy", busy[0], 0);
        chk_eq("mid_rst_r1", r1[0], 8'hFF);
        rst = 1'b0;
        repeat (1200) @(negedge clk);
        chk_eq("mid_rst_no_done", done_cnt[0], dc);

        // Randomised commands on both instances.
        for (int n = 0; n < 8; n++) begin
            ridx = 6'($urandom);
            rarg = $urandom;
            rcrc = 7'($urandom);
            rval = 8'($urandom);
            if ($urandom_range(0, 3) != 0) rval[7] = 1'b0;
            run_cmd(n % 2, ridx, rarg, rcrc, int'($urandom_range(0, 10)), rval, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
